// File: rtl/frame_pkg.sv
// Frame buffer geometry, header format and sequencer state encoding.
// Shared by the receive sequencer, frame packager and display path.
package frame_pkg;

  localparam int unsigned FRAME_PIXELS = 76800;
  localparam int unsigned ADDR_BYTES   = 3;
  localparam int unsigned ADDR_W       = 8 * ADDR_BYTES;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PIX,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Count updates the cycle after inc; no backpressure.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/frame_rx_sequencer.sv
// Parses packet start-address headers, forwards in-bounds pixel bytes and commits gap-free frames.
// One cycle from input byte to registered output; no backpressure, input is never stalled.
module frame_rx_sequencer #(
  parameter int unsigned FRAME_PIXELS = frame_pkg::FRAME_PIXELS,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [7:0]       axiid,
  output logic             addr_axiov,
  output logic [23:0]      addr_axiod,
  output logic             pixel_axiov,
  output logic [7:0]       pixel_axiod,
  output logic             bank_sel,
  output logic             frame_done,
  output logic [CNT_W-1:0] oob_count,
  output logic [CNT_W-1:0] runt_count
);

  import frame_pkg::*;

  localparam addr_t      FP_A     = addr_t'(FRAME_PIXELS);
  localparam logic [1:0] HDR_LAST = 2'(ADDR_BYTES - 1);

  seq_state_t state_q, state_d;
  addr_t      hdr_q, hdr_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  addr_t      cur_addr_q, cur_addr_d;
  addr_t      expected_addr_q, expected_addr_d;
  logic       frame_ok_q, frame_ok_d;
  logic       bank_sel_q, bank_sel_d;
  logic       addr_axiov_q, addr_axiov_d;
  addr_t      addr_axiod_q, addr_axiod_d;
  logic       pixel_axiov_q, pixel_axiov_d;
  logic [7:0] pixel_axiod_q, pixel_axiod_d;
  logic       frame_done_q, frame_done_d;
  logic       oob_inc;
  logic       runt_inc;
  addr_t      hdr_shift;

  always_comb begin
    state_d         = state_q;
    hdr_d           = hdr_q;
    byte_cnt_d      = byte_cnt_q;
    cur_addr_d      = cur_addr_q;
    expected_addr_d = expected_addr_q;
    frame_ok_d      = frame_ok_q;
    bank_sel_d      = bank_sel_q;
    addr_axiov_d    = 1'b0;
    addr_axiod_d    = addr_axiod_q;
    pixel_axiov_d   = 1'b0;
    pixel_axiod_d   = pixel_axiod_q;
    frame_done_d    = 1'b0;
    oob_inc         = 1'b0;
    runt_inc        = 1'b0;
    hdr_shift       = {hdr_q[ADDR_W-9:0], axiid};

    // Packets are contiguous, so axiiv low in any non-idle state is the packet end.
    case (state_q)
      IDLE: begin
        if (axiiv) begin
          hdr_d      = hdr_shift;
          byte_cnt_d = 2'd1;
          state_d    = HDR;
        end
      end
      HDR: begin
        if (!axiiv) begin
          runt_inc   = 1'b1;
          frame_ok_d = 1'b0;
          state_d    = IDLE;
        end else begin
          hdr_d      = hdr_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == HDR_LAST) begin
            if (hdr_shift < FP_A) begin
              state_d      = PIX;
              cur_addr_d   = hdr_shift;
              addr_axiov_d = 1'b1;
              addr_axiod_d = hdr_shift;
              // Address 0 always restarts a frame, even if it also matches expected.
              if (hdr_shift == '0) begin
                frame_ok_d = 1'b1;
              end else if (hdr_shift != expected_addr_q) begin
                frame_ok_d = 1'b0;
              end
            end else begin
              oob_inc    = 1'b1;
              frame_ok_d = 1'b0;
              state_d    = DRAIN;
            end
          end
        end
      end
      PIX: begin
        if (!axiiv) begin
          state_d = IDLE;
          if (cur_addr_q == FP_A) begin
            expected_addr_d = '0;
            if (frame_ok_q) begin
              frame_done_d = 1'b1;
              bank_sel_d   = ~bank_sel_q;
            end
          end else begin
            expected_addr_d = cur_addr_q;
          end
        end else if (cur_addr_q < FP_A) begin
          pixel_axiov_d = 1'b1;
          pixel_axiod_d = axiid;
          cur_addr_d    = cur_addr_q + addr_t'(1);
        end else begin
          oob_inc    = 1'b1;
          frame_ok_d = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (!axiiv) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      hdr_q           <= '0;
      byte_cnt_q      <= '0;
      cur_addr_q      <= '0;
      expected_addr_q <= '0;
      frame_ok_q      <= 1'b0;
      bank_sel_q      <= 1'b0;
      addr_axiov_q    <= 1'b0;
      addr_axiod_q    <= '0;
      pixel_axiov_q   <= 1'b0;
      pixel_axiod_q   <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      hdr_q           <= hdr_d;
      byte_cnt_q      <= byte_cnt_d;
      cur_addr_q      <= cur_addr_d;
      expected_addr_q <= expected_addr_d;
      frame_ok_q      <= frame_ok_d;
      bank_sel_q      <= bank_sel_d;
      addr_axiov_q    <= addr_axiov_d;
      addr_axiod_q    <= addr_axiod_d;
      pixel_axiov_q   <= pixel_axiov_d;
      pixel_axiod_q   <= pixel_axiod_d;
      frame_done_q    <= frame_done_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_oob_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (oob_inc),
    .count (oob_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_runt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (runt_inc),
    .count (runt_count)
  );

  assign addr_axiov  = addr_axiov_q;
  assign addr_axiod  = addr_axiod_q;
  assign pixel_axiov = pixel_axiov_q;
  assign pixel_axiod = pixel_axiod_q;
  assign bank_sel    = bank_sel_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_frame_rx_sequencer.sv
// Directed bench for frame_rx_sequencer with a 16-pixel frame; a scoreboard queue holds
// expected header addresses and pixel bytes, popped as the DUT presents them.
module tb_frame_rx_sequencer;

  localparam int FP    = 16;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             axiiv;
  logic [7:0]       axiid;
  logic             addr_axiov;
  logic [23:0]      addr_axiod;
  logic             pixel_axiov;
  logic [7:0]       pixel_axiod;
  logic             bank_sel;
  logic             frame_done;
  logic [CNT_W-1:0] oob_count;
  logic [CNT_W-1:0] runt_count;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [23:0] addr_q[$];
  logic [7:0]  pix_q[$];

  frame_rx_sequencer #(.FRAME_PIXELS(FP), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .addr_axiov  (addr_axiov),
    .addr_axiod  (addr_axiod),
    .pixel_axiov (pixel_axiov),
    .pixel_axiod (pixel_axiod),
    .bank_sel    (bank_sel),
    .frame_done  (frame_done),
    .oob_count   (oob_count),
    .runt_count  (runt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] ea;
    logic [7:0]  ep;
    if (addr_axiov) begin
      if (addr_q.size() == 0) begin
        chk("addr_unexpected", 32'(addr_axiov), 32'd0);
      end else begin
        ea = addr_q.pop_front();
        chk("addr_dat", 32'(addr_axiod), 32'(ea));
      end
    end
    if (pixel_axiov) begin
      if (pix_q.size() == 0) begin
        chk("pix_unexpected", 32'(pixel_axiov), 32'd0);
      end else begin
        ep = pix_q.pop_front();
        chk("pix_dat", 32'(pixel_axiod), 32'(ep));
      end
    end
    if (addr_axiov && pixel_axiov) begin
      chk("addr_pix_overlap", 32'(pixel_axiov), 32'd0);
    end
    if (frame_done) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    axiiv = 1'b1;
    axiid = b;
  endtask

  task automatic end_pkt();
    @(negedge clk);
    axiiv = 1'b0;
    axiid = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Header then n pixel bytes (base, base+0x11, ...); expectations follow the frame bounds.
  task automatic send_packet(input logic [23:0] a, input int n, input logic [7:0] base);
    logic [7:0] b;
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    if (32'(a) < FP) addr_q.push_back(a);
    for (int i = 0; i < n; i++) begin
      b = base + 8'(17 * i);
      if (32'(a) + i < FP) pix_q.push_back(b);
      send_byte(b);
    end
    end_pkt();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr_v"}, 32'(addr_axiov), 32'd0);
    chk({tag, "_addr_d"}, 32'(addr_axiod), 32'd0);
    chk({tag, "_pix_v"}, 32'(pixel_axiov), 32'd0);
    chk({tag, "_pix_d"}, 32'(pixel_axiod), 32'd0);
    chk({tag, "_bank"}, 32'(bank_sel), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_oob"}, 32'(oob_count), 32'd0);
    chk({tag, "_runt"}, 32'(runt_count), 32'd0);
  endtask

  initial begin
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = 8'h00;
    #2;
    chk_outputs_zero("reset");
    chk("reset_exp_addr", 32'(dut.expected_addr_q), 32'd0);
    chk("reset_frame_ok", 32'(dut.frame_ok_q), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // First frame start and a non-contiguous packet
    send_packet(24'h000000, 2, 8'h01);
    idle(3);
    chk("a_frame_ok", 32'(dut.frame_ok_q), 32'd1);
    chk("a_exp_addr", 32'(dut.expected_addr_q), 32'd2);
    send_packet(24'h000005, 3, 8'hAA);
    idle(3);
    chk("b_exp_addr", 32'(dut.expected_addr_q), 32'd8);
    chk("b_frame_ok", 32'(dut.frame_ok_q), 32'd0);

    // Two complete frames toggle the bank out and back
    send_packet(24'h000000, 8, 8'h10);
    send_packet(24'h000008, 8, 8'h20);
    idle(3);
    chk("c_done_cnt", 32'(done_cnt), 32'd1);
    chk("c_bank", 32'(bank_sel), 32'd1);
    chk("c_exp_addr", 32'(dut.expected_addr_q), 32'd0);
    send_packet(24'h000000, 8, 8'h30);
    send_packet(24'h000008, 8, 8'h40);
    idle(3);
    chk("d_done_cnt", 32'(done_cnt), 32'd2);
    chk("d_bank", 32'(bank_sel), 32'd0);

    // Gap in coverage: reaches the end but does not commit
    send_packet(24'h000000, 8, 8'h50);
    send_packet(24'h00000C, 4, 8'h60);
    idle(3);
    chk("e_done_cnt", 32'(done_cnt), 32'd2);
    chk("e_bank", 32'(bank_sel), 32'd0);
    chk("e_exp_addr", 32'(dut.expected_addr_q), 32'd0);
    send_packet(24'h000000, 8, 8'h70);
    send_packet(24'h000008, 8, 8'h80);
    idle(3);
    chk("f_done_cnt", 32'(done_cnt), 32'd3);
    chk("f_bank", 32'(bank_sel), 32'd1);

    // Reset in the middle of a pixel run
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    addr_q.push_back(24'h000000);
    pix_q.push_back(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = 8'h00;
    #1;
    chk_outputs_zero("midrst");
    idle(2);
    rst = 1'b1;
    idle(2);
    chk("midrst_addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("midrst_pix_q_empty", 32'(pix_q.size()), 32'd0);

    // Back-to-back packets after reset, header 0 restarts the frame
    send_packet(24'h000000, 3, 8'h90);
    send_packet(24'h000003, 3, 8'hA0);
    idle(3);
    chk("g_frame_ok", 32'(dut.frame_ok_q), 32'd1);
    chk("g_exp_addr", 32'(dut.expected_addr_q), 32'd6);

    // Pixel overrun, then out-of-range headers (one exercises MSB-first order)
    send_packet(24'h00000E, 5, 8'hB0);
    idle(3);
    chk("h_oob", 32'(oob_count), 32'd1);
    chk("h_exp_addr", 32'(dut.expected_addr_q), 32'd6);
    chk("h_frame_ok", 32'(dut.frame_ok_q), 32'd0);
    send_packet(24'h000020, 2, 8'hC0);
    send_packet(24'h010000, 1, 8'hC5);
    idle(3);
    chk("i_oob", 32'(oob_count), 32'd3);

    // Runt packet and a header-only packet
    send_byte(8'h00);
    send_byte(8'h00);
    end_pkt();
    idle(3);
    chk("j_runt", 32'(runt_count), 32'd1);
    chk("j_exp_addr", 32'(dut.expected_addr_q), 32'd6);
    send_packet(24'h000009, 0, 8'h00);
    idle(3);
    chk("k_exp_addr", 32'(dut.expected_addr_q), 32'd9);
    chk("k_done_cnt", 32'(done_cnt), 32'd3);

    idle(4);
    chk("end_addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("end_pix_q_empty", 32'(pix_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
